orb_frame_serializer: RTL and testbench

- Downstream/upstream partner of the temperature word packer.
- Holds the orbital frame in a ping-pong 12-bit word memory. The packer writes into the idle bank through WE/WrAddr/orbWord.
- Transmits the other bank as an NRZ serial stream, MSB first.
- Generates the word address (addrRam), word strobe (strob) and bank flag (SW) that drive the packer, closing the loop.

---
 rtl/orb_frame_serializer.sv | 191 +++++++++++++++++++
 tb/tb_orb_frame_serializer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/orb_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : orb_frame_serializer
//  Purpose  : Ping-pong 12-bit word memory with an NRZ MSB-first serial
//             transmitter. The packer fills the idle bank while the other
//             bank is shifted out. Word address, word strobe and bank flag
//             are generated here to pace the packer.
//  Revision : 1.0 - initial release
// ============================================================================
module orb_frame_serializer #(
  parameter int WORDS      = 2048,
  parameter int BIT_DIV    = 8,
  parameter int STROB_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        WE,
  input  logic [10:0] WrAddr,
  input  logic [11:0] orbWord,
  output logic [10:0] addrRam,
  output logic        strob,
  output logic        SW,
  output logic        serOut,
  output logic        serClk,
  output logic        frameSync,
  output logic        busy
);

  localparam int              c_AW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int              c_DW        = $clog2(BIT_DIV);
  localparam logic [c_DW-1:0] c_DIV_LAST  = c_DW'(BIT_DIV - 1);
  localparam logic [c_DW-1:0] c_DIV_PRE   = c_DW'(BIT_DIV - 2);
  localparam logic [c_DW-1:0] c_DIV_HALF  = c_DW'(BIT_DIV / 2);
  localparam logic [c_DW-1:0] c_DIV_ONE   = c_DW'(1);
  localparam logic [3:0]      c_BIT_LAST  = 4'd11;
  localparam logic [3:0]      c_STROB_END = 4'(STROB_BITS);
  localparam logic [10:0]     c_ADDR_LAST = 11'(WORDS - 1);
  localparam logic [11:0]     c_WORDS_EXT = 12'(WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [11:0]      r_mem [0:1][0:WORDS-1];
  logic [11:0]      r_rdata;
  logic [11:0]      r_shreg;
  logic [3:0]       r_bit;
  logic [c_DW-1:0]  r_div;
  logic [10:0]      r_addr;
  logic             r_rdbank;
  logic             r_fsync;

  logic             w_rd_en;
  logic             w_rd_bank;
  logic [c_AW-1:0]  w_rd_addr;
  logic             w_bit_end;
  logic             w_prefetch;
  logic             w_word_end;
  logic             w_wrap;
  logic [10:0]      w_addr_next;

  // Bit/word position decode shared by the FSM and the datapath.
  assign w_bit_end   = (r_div == c_DIV_LAST);
  assign w_prefetch  = (r_state == S_SHIFT) && (r_bit == c_BIT_LAST) && (r_div == c_DIV_PRE);
  assign w_word_end  = (r_state == S_SHIFT) && (r_bit == c_BIT_LAST) && w_bit_end;
  assign w_wrap      = (r_addr == c_ADDR_LAST);
  assign w_addr_next = w_wrap ? 11'd0 : (r_addr + 11'd1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and read-port control. The prefetch at the frame wrap already
  // targets the bank that becomes the read bank one cycle later.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_rd_bank    = r_rdbank;
    w_rd_addr    = '0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_rd_en      = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_prefetch) begin
          w_rd_en   = 1'b1;
          w_rd_addr = w_addr_next[c_AW-1:0];
          w_rd_bank = r_rdbank ^ w_wrap;
        end
        if (w_word_end && w_wrap && !en) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Bit timing, shift register, word address, bank flag and frame pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg  <= '0;
      r_bit    <= '0;
      r_div    <= '0;
      r_addr   <= '0;
      r_rdbank <= 1'b0;
      r_fsync  <= 1'b0;
    end else begin
      r_fsync <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_bit   <= '0;
          r_div   <= '0;
          r_fsync <= en;
        end
        S_LOAD: begin
          r_shreg <= r_rdata;
          r_bit   <= '0;
          r_div   <= '0;
        end
        S_SHIFT: begin
          if (w_bit_end) begin
            r_div <= '0;
            if (r_bit == c_BIT_LAST) begin
              // Next word drops straight in: no gap between words.
              r_shreg <= r_rdata;
              r_bit   <= '0;
              r_addr  <= w_addr_next;
              if (w_wrap) begin
                r_rdbank <= ~r_rdbank;
                r_fsync  <= en;
              end
            end else begin
              r_shreg <= {r_shreg[10:0], 1'b0};
              r_bit   <= r_bit + 4'd1;
            end
          end else begin
            r_div <= r_div + c_DIV_ONE;
          end
        end
        default: begin
          r_bit <= '0;
          r_div <= '0;
        end
      endcase
    end
  end

  // Packer writes always land in the bank not being read; out-of-range
  // addresses are dropped.
  always_ff @(posedge clk) begin
    if (WE && ({1'b0, WrAddr} < c_WORDS_EXT)) begin
      r_mem[~r_rdbank][WrAddr[c_AW-1:0]] <= orbWord;
    end
  end

  // Synchronous read port, one cycle latency.
  always_ff @(posedge clk) begin
    if (w_rd_en) begin
      r_rdata <= r_mem[w_rd_bank][w_rd_addr];
    end
  end

  assign serOut    = (r_state == S_SHIFT) && r_shreg[11];
  assign serClk    = (r_state == S_SHIFT) && (r_div < c_DIV_HALF);
  assign strob     = (r_state == S_SHIFT) && (r_bit < c_STROB_END);
  assign addrRam   = r_addr;
  assign SW        = r_rdbank;
  assign frameSync = r_fsync;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_orb_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_orb_frame_serializer
//  Purpose  : Scoreboard bench for orb_frame_serializer (WORDS=4, BIT_DIV=8).
//             Stimulus pushes expected words; a monitor deserialises the
//             stream and checks data, address, bank, sync and bit timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_orb_frame_serializer;

  localparam int WORDS      = 4;
  localparam int BIT_DIV    = 8;
  localparam int STROB_BITS = 6;
  localparam int c_WORD_CYC = 12 * BIT_DIV;
  localparam int c_STROB_HI = STROB_BITS * BIT_DIV;
  localparam int c_CLK_HI   = 12 * (BIT_DIV / 2);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        WE = 1'b0;
  logic [10:0] WrAddr = 11'd0;
  logic [11:0] orbWord = 12'd0;
  logic [10:0] addrRam;
  logic        strob;
  logic        SW;
  logic        serOut;
  logic        serClk;
  logic        frameSync;
  logic        busy;

  orb_frame_serializer #(
    .WORDS      (WORDS),
    .BIT_DIV    (BIT_DIV),
    .STROB_BITS (STROB_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .WE        (WE),
    .WrAddr    (WrAddr),
    .orbWord   (orbWord),
    .addrRam   (addrRam),
    .strob     (strob),
    .SW        (SW),
    .serOut    (serOut),
    .serClk    (serClk),
    .frameSync (frameSync),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    logic [10:0] addr;
    logic        sw;
    bit          care;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic int outvec();
    return int'({addrRam, strob, SW, serOut, serClk, frameSync, busy});
  endfunction

  task automatic push_frame(input logic sw, input logic [11:0] d0, input logic [11:0] d1,
                            input logic [11:0] d2, input logic [11:0] d3,
                            input bit care, input int nwords);
    logic [11:0] d [4];
    exp_t e;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < nwords; i++) begin
      e.data = d[i];
      e.addr = 11'(i);
      e.sw   = sw;
      e.care = care;
      q.push_back(e);
    end
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic wr(input logic [10:0] a, input logic [11:0] d);
    WE = 1'b1; WrAddr = a; orbWord = d;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic wait_word(input logic sw, input logic [10:0] a, input string nm);
    bit ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = busy && (SW == sw) && (addrRam == a);
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout, got SW=%0d addrRam=%0d, expected SW=%0d addrRam=%0d",
               nm, SW, addrRam, sw, a);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = !busy;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout, got busy=%0d, expected 0", nm, busy);
    end
  endtask

  // ---------------- monitor ----------------
  int          bits = 0, cyc = 0, shi = 0, chi = 0, glitch = 0, fs_total = 0;
  bit          in_word = 1'b0, word_fs = 1'b0;
  logic        prev_clk = 1'b0, fs_prev = 1'b0;
  logic [11:0] cur = 12'd0;
  logic [10:0] w_addr = 11'd0;
  logic        w_sw = 1'b0;

  task automatic finish_word();
    check("word_period", cyc, c_WORD_CYC);
    check("strob_high_cycles", shi, c_STROB_HI);
    check("serclk_high_cycles", chi, c_CLK_HI);
    check("hold_glitches", glitch, 0);
  endtask

  task automatic compare_word();
    exp_t e;
    if (q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected_word: got 0x%03h addr %0d, expected no word", cur, w_addr);
    end else begin
      e = q.pop_front();
      if (e.care) check("word_data", int'(cur), int'(e.data));
      check("word_addrRam", int'(w_addr), int'(e.addr));
      check("word_SW", int'(w_sw), int'(e.sw));
      check("word_frameSync", int'(word_fs), int'(e.addr == 11'd0));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (frameSync === 1'b1) fs_total++;
      if (busy !== 1'b1) begin
        if (in_word && bits == 0) finish_word();
        in_word = 1'b0;
        bits    = 0;
      end else begin
        if (serClk && !prev_clk) begin
          if (bits == 0) begin
            if (in_word) finish_word();
            in_word = 1'b1;
            cyc = 0; shi = 0; chi = 0; glitch = 0;
            w_addr  = addrRam;
            w_sw    = SW;
            word_fs = frameSync | fs_prev;
          end
          cur = {cur[10:0], serOut};
          bits++;
          if (bits == 12) begin
            compare_word();
            bits = 0;
          end
        end
        if (in_word) begin
          cyc++;
          shi += int'(strob);
          chi += int'(serClk);
          if (serOut != cur[0] || addrRam != w_addr || SW != w_sw) glitch++;
        end
      end
      prev_clk = serClk;
      fs_prev  = frameSync;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outvec(), 0);
    rst = 1'b1;
    @(negedge clk);

    // Idle: read bank is 0, so these land in bank 1. Address 4 is out of range.
    wr(11'd0, 12'hA5C);
    wr(11'd1, 12'h001);
    wr(11'd2, 12'h002);
    wr(11'd3, 12'h003);
    wr(11'd4, 12'hBAD);
    repeat (5) @(negedge clk);
    check("idle_outputs", outvec(), 0);

    // Frame 0 (bank 0, contents unknown) then frame 1 (bank 1).
    push_frame(1'b0, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0, 4);
    push_frame(1'b1, 12'hA5C, 12'h001, 12'h002, 12'h003, 1'b1, 4);
    en = 1'b1;

    // During frame 1 fill bank 0.
    wait_word(1'b1, 11'd1, "wait_f1_w1");
    wr(11'd0, 12'h111);
    wr(11'd1, 12'h222);
    wr(11'd2, 12'h333);
    wr(11'd3, 12'h444);
    push_frame(1'b0, 12'h111, 12'h222, 12'h333, 12'h444, 1'b1, 4);

    // During frame 2 word 1: write bank 1 and drop en; frame must complete.
    wait_word(1'b0, 11'd1, "wait_f2_w1");
    wr(11'd2, 12'hFFF);
    en = 1'b0;
    wait_idle("wait_f2_end");
    check("SW_after_stop", int'(SW), 1);
    check("outputs_after_stop", outvec(), int'({11'd0, 1'b0, 1'b1, 4'b0000}));

    // Restart from bank 1 at address 0.
    push_frame(1'b1, 12'hA5C, 12'h001, 12'hFFF, 12'h003, 1'b1, 4);
    en = 1'b1;
    wait_word(1'b1, 11'd1, "wait_f3_w1");
    en = 1'b0;
    wait_idle("wait_f3_end");
    check("SW_after_f3", int'(SW), 0);

    // Reset in the middle of word 1.
    push_frame(1'b0, 12'h111, 12'h222, 12'h333, 12'h444, 1'b1, 1);
    en = 1'b1;
    wait_word(1'b0, 11'd1, "wait_f4_w1");
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("reset_mid_shift", outvec(), 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (outvec() != 0) bad++;
    end
    check("idle_200_cycles", bad, 0);

    // After reset the frame restarts from bank 0, address 0.
    push_frame(1'b0, 12'h111, 12'h222, 12'h333, 12'h444, 1'b1, 4);
    en = 1'b1;
    wait_word(1'b0, 11'd2, "wait_f5_w2");
    en = 1'b0;
    wait_idle("wait_f5_end");
    repeat (10) @(negedge clk);

    check("frameSync_total", fs_total, 6);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
